// File: rtl/input_matrix_loader.sv
// Fetches one NUM_BANKS x ROWS_PER_BANK word matrix from a latency-configurable ROM into a
// bank/row register array with a registered read port. Optional LOADER_PINGPONG_EN adds a shadow copy.
module input_matrix_loader #(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned ELEMS         = 4,
   parameter int unsigned ADDR_WIDTH    = 8,
   parameter int unsigned NUM_BANKS     = 4,
   parameter int unsigned ROWS_PER_BANK = 4,
   parameter int unsigned ROM_LATENCY   = 1,
   localparam int unsigned W  = DATA_WIDTH * ELEMS,
   localparam int unsigned T  = NUM_BANKS * ROWS_PER_BANK,
   localparam int unsigned CW = $clog2(T + 1),
   localparam int unsigned BW = $clog2(NUM_BANKS),
   localparam int unsigned RW = $clog2(ROWS_PER_BANK)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   output logic                  rom_rd_en,
   input  logic [W-1:0]          rom_data,
   input  logic [BW-1:0]         rd_bank,
   input  logic [RW-1:0]         rd_row,
   output logic [W-1:0]          rd_data,
   output logic                  busy,
   output logic                  done,
   output logic [CW-1:0]         count,
   output logic                  active_buf
);

`ifdef LOADER_PINGPONG_EN
   localparam int unsigned NBUF = 2;
`else
   localparam int unsigned NBUF = 1;
`endif

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   base_q;
   logic [CW-1:0]           issue_idx;
   logic [ROM_LATENCY-1:0]  vld;
   logic                    cap;
   logic [BW+RW-1:0]        wr_idx;
   logic [BW+RW-1:0]        rd_idx;
   logic                    wr_buf;
   logic                    rd_buf;
   logic [W-1:0]            mem [NBUF][T];

   // Valid pipe output marks the cycle in which rom_data belongs to word `count`
   assign cap    = vld[ROM_LATENCY-1];
   assign wr_idx = (BW+RW)'(count);
   assign rd_idx = {rd_bank, rd_row};

`ifdef LOADER_PINGPONG_EN
   assign wr_buf = ~active_buf;
   assign rd_buf = active_buf;
`else
   assign wr_buf     = 1'b0;
   assign rd_buf     = 1'b0;
   assign active_buf = 1'b0;
`endif

   // Load sequencer: address issue, capture counting and completion
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         base_q    <= '0;
         issue_idx <= '0;
         vld       <= '0;
         rom_addr  <= '0;
         rom_rd_en <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         count     <= '0;
`ifdef LOADER_PINGPONG_EN
         active_buf <= 1'b0;
`endif
      end else begin
         vld <= ROM_LATENCY'({vld, rom_rd_en});
         if (cap) count <= count + CW'(1);
         case (state)
            IDLE: begin
               rom_rd_en <= 1'b0;
               if (start) begin
                  base_q    <= base_addr;
                  rom_addr  <= base_addr;
                  rom_rd_en <= enable;
                  issue_idx <= enable ? CW'(1) : '0;
                  count     <= '0;
                  busy      <= 1'b1;
                  state     <= FETCH;
               end
            end
            FETCH: begin
               if (enable) begin
                  rom_addr  <= base_q + ADDR_WIDTH'(issue_idx);
                  rom_rd_en <= 1'b1;
                  issue_idx <= issue_idx + CW'(1);
                  if (issue_idx == CW'(T - 1)) state <= DRAIN;
               end else begin
                  rom_rd_en <= 1'b0;
               end
            end
            DRAIN: begin
               rom_rd_en <= 1'b0;
               if (cap && count == CW'(T - 1)) begin
                  state <= DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
`ifdef LOADER_PINGPONG_EN
                  active_buf <= ~active_buf;
`endif
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Matrix storage; captures land in the shadow copy when ping-pong is built in
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem <= '{default: '0};
      end else if (cap) begin
         mem[wr_buf][wr_idx] <= rom_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) rd_data <= '0;
      else       rd_data <= mem[rd_buf][rd_idx];
   end

endmodule

// File: tb/tb_input_matrix_loader.sv
// Directed bench for input_matrix_loader: two instances (ROM latency 1 and 3) share stimulus,
// each fed by its own ROM model where word at address a is a replicated across all elements.
module tb_input_matrix_loader;

`ifdef LOADER_PINGPONG_EN
   localparam bit PP = 1'b1;
`else
   localparam bit PP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        start;
   logic [7:0]  base_addr;
   logic [1:0]  rd_bank;
   logic [1:0]  rd_row;

   logic [7:0]  rom_addr1, rom_addr3;
   logic        rom_rd_en1, rom_rd_en3;
   logic [31:0] rom_data1, rom_data3;
   logic [31:0] rd_data1, rd_data3;
   logic        busy1, busy3, done1, done3, active1, active3;
   logic [4:0]  count1, count3;

   logic [31:0] rom_p1;
   logic [31:0] rom_p3 [3];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   input_matrix_loader #(.ROM_LATENCY(1)) u_l1 (
      .clk(clk), .reset(reset), .enable(enable), .start(start), .base_addr(base_addr),
      .rom_addr(rom_addr1), .rom_rd_en(rom_rd_en1), .rom_data(rom_data1),
      .rd_bank(rd_bank), .rd_row(rd_row), .rd_data(rd_data1),
      .busy(busy1), .done(done1), .count(count1), .active_buf(active1)
   );

   input_matrix_loader #(.ROM_LATENCY(3)) u_l3 (
      .clk(clk), .reset(reset), .enable(enable), .start(start), .base_addr(base_addr),
      .rom_addr(rom_addr3), .rom_rd_en(rom_rd_en3), .rom_data(rom_data3),
      .rd_bank(rd_bank), .rd_row(rd_row), .rd_data(rd_data3),
      .busy(busy3), .done(done3), .count(count3), .active_buf(active3)
   );

   // ROM models: address sampled at an edge, data valid ROM_LATENCY edges later
   always @(posedge clk) begin
      rom_p1    <= {4{rom_addr1}};
      rom_p3[0] <= {4{rom_addr3}};
      rom_p3[1] <= rom_p3[0];
      rom_p3[2] <= rom_p3[1];
   end
   assign rom_data1 = rom_p1;
   assign rom_data3 = rom_p3[2];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One load; pause_at>0 drops enable for 3 cycles after that many ticks
   task automatic run_load(input logic [7:0] base, input int pause_at, output int lat1, output int lat3);
      logic [7:0] q[$];
      logic [7:0] held;
      int n;
      logic [7:0] exp_a;
      lat1 = -1;
      lat3 = -1;
      held = '0;
      enable    = 1'b1;
      base_addr = base;
      start     = 1'b1;
      tick();
      n = 1;
      start = 1'b0;
      check("start_busy", 64'(busy1), 64'd1);
      if (rom_rd_en1) q.push_back(rom_addr1);
      while ((lat1 < 0 || lat3 < 0) && n < 100) begin
         if (n == 4) begin start = 1'b1; base_addr = 8'hAA; end
         else begin start = 1'b0; base_addr = base; end
         if (pause_at > 0 && n == pause_at) begin held = rom_addr1; enable = 1'b0; end
         if (pause_at > 0 && n == pause_at + 3) enable = 1'b1;
         tick();
         n++;
         if (rom_rd_en1) q.push_back(rom_addr1);
         if (pause_at > 0 && n > pause_at && n <= pause_at + 3) begin
            check("pause_rd_en", 64'(rom_rd_en1), 64'd0);
            check("pause_addr_hold", 64'(rom_addr1), 64'(held));
         end
         if (lat1 > 0 && n == lat1 + 1) check("done_one_cycle", 64'(done1), 64'd0);
         if (done1 && lat1 < 0) begin
            lat1 = n;
            check("count_at_done", 64'(count1), 64'd16);
            check("busy_at_done", 64'(busy1), 64'd0);
         end
         if (done3 && lat3 < 0) begin
            lat3 = n;
            check("count_at_done_l3", 64'(count3), 64'd16);
         end
      end
      start     = 1'b0;
      enable    = 1'b1;
      base_addr = base;
      check("issue_count", 64'(q.size()), 64'd16);
      for (int i = 0; i < 16 && i < q.size(); i++) begin
         exp_a = base + 8'(i);
         check($sformatf("issue_addr[%0d]", i), 64'(q[i]), 64'(exp_a));
      end
   endtask

   task automatic read_all(input logic [7:0] base);
      logic [7:0] b;
      for (int i = 0; i < 16; i++) begin
         rd_bank = 2'(i / 4);
         rd_row  = 2'(i % 4);
         tick();
         b = base + 8'(i);
         check($sformatf("word_l1[%0d]", i), 64'(rd_data1), 64'({4{b}}));
         check($sformatf("word_l3[%0d]", i), 64'(rd_data3), 64'({4{b}}));
      end
   endtask

   initial begin
      int l1, l3, n;
      bit seen;
      reset = 1'b1; enable = 1'b0; start = 1'b0; base_addr = '0; rd_bank = '0; rd_row = '0;
      tick();
      tick();
      check("rst_rom_addr", 64'(rom_addr1), 64'd0);
      check("rst_rd_en", 64'(rom_rd_en1), 64'd0);
      check("rst_rd_data", 64'(rd_data1), 64'd0);
      check("rst_busy", 64'(busy1), 64'd0);
      check("rst_done", 64'(done1), 64'd0);
      check("rst_count", 64'(count1), 64'd0);
      check("rst_active", 64'(active1), 64'd0);
      check("rst_count_l3", 64'(count3), 64'd0);
      reset = 1'b0;
      tick();

      // Baseline load from 0x10
      run_load(8'h10, 0, l1, l3);
      check("lat_l1", 64'(l1), 64'd18);
      check("lat_l3", 64'(l3), 64'd20);
      read_all(8'h10);
      rd_bank = 2'd2; rd_row = 2'd3;
      tick();
      check("bank2_row3", 64'(rd_data1), 64'h1B1B1B1B);

      // Same load with a 3-cycle enable gap, from a cleared array
      reset = 1'b1;
      tick();
      reset = 1'b0;
      run_load(8'h10, 6, l1, l3);
      check("lat_pause_l1", 64'(l1), 64'd21);
      check("lat_pause_l3", 64'(l3), 64'd23);
      read_all(8'h10);

      // Address wrap past 0xFF
      run_load(8'hFC, 0, l1, l3);
      check("lat_wrap_l1", 64'(l1), 64'd18);
      read_all(8'hFC);

      // Abort a load once 7 words are captured
      base_addr = 8'h30; start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (count1 != 5'd7 && n < 50) begin tick(); n++; end
      check("reached_count7", 64'(count1), 64'd7);
      #2 reset = 1'b1;
      #1;
      check("abort_rom_addr", 64'(rom_addr1), 64'd0);
      check("abort_rd_en", 64'(rom_rd_en1), 64'd0);
      check("abort_busy", 64'(busy1), 64'd0);
      check("abort_count", 64'(count1), 64'd0);
      check("abort_rd_data", 64'(rd_data1), 64'd0);
      check("abort_done", 64'(done1), 64'd0);
      check("abort_count_l3", 64'(count3), 64'd0);
      tick();
      reset = 1'b0;
      rd_bank = '0; rd_row = '0;
      tick();
      tick();
      check("abort_array_clear", 64'(rd_data1), 64'd0);
      check("abort_busy_idle", 64'(busy1), 64'd0);

      // Load A after the abort
      run_load(8'h50, 0, l1, l3);
      check("lat_after_abort", 64'(l1), 64'd18);
      check("active_after_a", 64'(active1), PP ? 64'd1 : 64'd0);
      read_all(8'h50);

      // Load B while watching bank 0 row 0
      rd_bank = '0; rd_row = '0;
      tick();
      check("a_word0", 64'(rd_data1), 64'h50505050);
      base_addr = 8'h60; start = 1'b1;
      tick();
      start = 1'b0;
      seen = 1'b0;
      n = 0;
      while (!seen && n < 60) begin
         tick();
         n++;
         if (done1) seen = 1'b1;
         if (PP) check("pp_holds_a", 64'(rd_data1), 64'h50505050);
      end
      check("b_done_seen", 64'(seen), 64'd1);
      tick();
      check("b_word0", 64'(rd_data1), 64'h60606060);
      check("active_after_b", 64'(active1), 64'd0);
      check("active_after_b_l3", 64'(active3), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
